// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: reset/enable levels,
// bus widths, the all-zero word and the PC increment per instruction.
package inst_fetch_pkg;

   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        CHIP_ENABLE   = 1'b1;
   localparam logic        CHIP_DISABLE  = 1'b0;

   localparam int          INST_ADDR_BUS = 32;
   localparam int          INST_BUS      = 32;

   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic [31:0] INST_STEP     = 32'd4;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch unit, the instruction ROM, the redirect source
// and decode.
//
// Decode handshake: id_valid_o / id_ready_i. An entry transfers on every rising
// edge where both are 1. While id_valid_o is 1, id_pc_o / id_inst_o stay stable
// until the transfer or until a redirect flushes the queue. id_ready_i may be
// asserted with no entry present; nothing transfers in that case.
interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);

   logic              rom_ce_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [INST_W-1:0] rom_inst_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              id_valid_o;
   logic              id_ready_i;
   logic [ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0] id_inst_o;

   // Fetch unit side
   modport master (
      output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
      input  rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

   // ROM / redirect source / decode side
   modport slave (
      input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
      output rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

endinterface : inst_fetch_if

// File: rtl/inst_fetch_fetch_queue.sv
// Synchronous circular FIFO holding {pc, inst} entries between fetch and
// decode. Flush wins over push and pop. The head reads as zero when empty.
module fetch_queue #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic         o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

   // A write into a full queue is only legal when the head leaves the same cycle
   assign w_wr_en = i_push & ~i_flush & (~o_full | (i_pop & ~o_empty));
   assign w_rd_en = i_pop  & ~i_flush & ~o_empty;

   // Pointer and occupancy bookkeeping; flush and reset both empty the queue
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
      end
   end

   // Entry storage; contents are only meaningful where r_count says so
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_din;
   end

endmodule : fetch_queue

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the ROM, captures the
// combinational ROM data into the fetch queue and hands entries to decode.
// A redirect flushes the queue and restarts fetch at the word-aligned target.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W      = INST_ADDR_BUS,
   parameter int                INST_W      = INST_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(ZERO_WORD),
   parameter int                QUEUE_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus
);

   logic [ADDR_W-1:0]        r_pc;
   logic                     r_ce;
   logic                     w_empty;
   logic                     w_full;
   logic                     w_valid;
   logic                     w_pop;
   logic                     w_push;
   logic [ADDR_W-1:0]        w_redirect_pc;
   logic [ADDR_W+INST_W-1:0] w_din;
   logic [ADDR_W+INST_W-1:0] w_dout;

   assign w_valid       = ~w_empty;
   assign w_pop         = w_valid & bus.id_ready_i;
   // The instruction on the ROM this cycle belongs to r_pc; it is queued unless
   // the queue is full with nothing leaving, or a redirect discards it
   assign w_push        = r_ce & ~bus.redirect_i & (~w_full | w_pop);
   assign w_redirect_pc = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
   assign w_din         = {r_pc, bus.rom_inst_i};

   // PC and chip-enable: reset, redirect, advance on push, otherwise hold
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_pc <= RESET_PC;
         r_ce <= CHIP_DISABLE;
      end else begin
         r_ce <= CHIP_ENABLE;
         if (bus.redirect_i)
            r_pc <= w_redirect_pc;
         else if (w_push)
            r_pc <= r_pc + ADDR_W'(INST_STEP);
      end
   end

   fetch_queue #(
      .W     (ADDR_W + INST_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_i),
      .i_din   (w_din),
      .o_dout  (w_dout),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign bus.rom_ce_o                  = r_ce;
   assign bus.rom_addr_o                = r_pc;
   assign bus.id_valid_o                = w_valid;
   assign {bus.id_pc_o, bus.id_inst_o}  = w_dout;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a default-reset instance for streaming, stall,
// redirect and reset scenarios, and a second instance whose reset PC sits at
// the top of the address space for the wrap-around case.
module tb_inst_fetch;

   logic clk;
   logic rst;
   logic rst_w;

   int n_checks;
   int n_errors;

   logic [63:0] exp_q[$];

   inst_fetch_if if0 ();
   inst_fetch_if if1 ();

   // ROM model: word i holds 0x1000_0000 + i
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign if0.rom_inst_i = rom_word(if0.rom_addr_o);
   assign if1.rom_inst_i = rom_word(if1.rom_addr_o);

   inst_fetch u_dut (
      .clk (clk),
      .rst (rst),
      .bus (if0.master)
   );

   inst_fetch #(
      .RESET_PC (32'hFFFF_FFFC)
   ) u_dut_wrap (
      .clk (clk),
      .rst (rst_w),
      .bus (if1.master)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load the scoreboard with n consecutive fetches starting at pc
   task automatic exp_fill(input logic [31:0] pc, input int n);
      logic [31:0] a;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = pc + 32'(4 * i);
         exp_q.push_back({a, rom_word(a)});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if0.id_ready_i = 1'b1;
      if0.redirect_i = 1'b0;
      if0.redirect_pc_i = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (if0.rom_ce_o !== 1'b0) begin n_errors++; $display("FAIL reset_ce: got %b want 0", if0.rom_ce_o); end
      n_checks++; if (if0.rom_addr_o !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", if0.rom_addr_o); end
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", if0.id_valid_o); end
      n_checks++; if (if0.id_pc_o !== 32'h0) begin n_errors++; $display("FAIL reset_id_pc: got %h want 0", if0.id_pc_o); end
      n_checks++; if (if0.id_inst_o !== 32'h0) begin n_errors++; $display("FAIL reset_id_inst: got %h want 0", if0.id_inst_o); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (if0.rom_ce_o !== 1'b1) begin n_errors++; $display("FAIL start_ce: got %b want 1", if0.rom_ce_o); end
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL start_valid: got %b want 0", if0.id_valid_o); end
      n_checks++; if (if0.rom_addr_o !== 32'h0) begin n_errors++; $display("FAIL start_addr: got %h want 0", if0.rom_addr_o); end
      @(negedge clk);
   endtask

   task automatic test_stream();
      logic [63:0] e;
      exp_fill(32'h0, 8);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (if0.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, if0.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL stream_extra[%0d]: got %h want none", i, if0.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if0.id_pc_o, if0.id_inst_o} !== e) begin
               n_errors++; $display("FAIL stream_entry[%0d]: got %h want %h", i, {if0.id_pc_o, if0.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      logic [63:0] e;
      exp_fill(32'h20, 10);
      if0.id_ready_i = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (if0.rom_addr_o !== 32'h28) begin n_errors++; $display("FAIL stall_addr: got %h want 00000028", if0.rom_addr_o); end
      n_checks++; if (if0.id_pc_o !== 32'h20) begin n_errors++; $display("FAIL stall_head: got %h want 00000020", if0.id_pc_o); end
      if0.id_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (if0.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if0.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL stall_extra[%0d]: got %h want none", i, if0.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if0.id_pc_o, if0.id_inst_o} !== e) begin
               n_errors++; $display("FAIL stall_entry[%0d]: got %h want %h", i, {if0.id_pc_o, if0.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_full();
      logic [63:0] e;
      if0.id_ready_i = 1'b0;
      @(negedge clk);
      n_checks++; if (if0.rom_addr_o !== 32'h50) begin n_errors++; $display("FAIL full_hold_addr: got %h want 00000050", if0.rom_addr_o); end
      if0.redirect_i = 1'b1;
      if0.redirect_pc_i = 32'h0000_0040;
      if0.id_ready_i = 1'b1;
      @(negedge clk);
      if0.redirect_i = 1'b0;
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL redir_valid: got %b want 0", if0.id_valid_o); end
      n_checks++; if (if0.rom_addr_o !== 32'h40) begin n_errors++; $display("FAIL redir_addr: got %h want 00000040", if0.rom_addr_o); end
      n_checks++; if (if0.id_pc_o !== 32'h0) begin n_errors++; $display("FAIL redir_empty_pc: got %h want 0", if0.id_pc_o); end
      exp_fill(32'h40, 4);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (if0.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL redir_valid[%0d]: got %b want 1", i, if0.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL redir_extra[%0d]: got %h want none", i, if0.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if0.id_pc_o, if0.id_inst_o} !== e) begin
               n_errors++; $display("FAIL redir_entry[%0d]: got %h want %h", i, {if0.id_pc_o, if0.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_unaligned();
      logic [63:0] e;
      if0.redirect_i = 1'b1;
      if0.redirect_pc_i = 32'h0000_0043;
      @(negedge clk);
      if0.redirect_i = 1'b0;
      n_checks++; if (if0.rom_addr_o !== 32'h40) begin n_errors++; $display("FAIL unaligned_addr: got %h want 00000040", if0.rom_addr_o); end
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL unaligned_valid: got %b want 0", if0.id_valid_o); end
      exp_fill(32'h40, 3);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (if0.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL unaligned_valid[%0d]: got %b want 1", i, if0.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL unaligned_extra[%0d]: got %h want none", i, if0.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if0.id_pc_o, if0.id_inst_o} !== e) begin
               n_errors++; $display("FAIL unaligned_entry[%0d]: got %h want %h", i, {if0.id_pc_o, if0.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] e;
      if0.id_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (if0.rom_addr_o !== 32'h54) begin n_errors++; $display("FAIL mid_full_addr: got %h want 00000054", if0.rom_addr_o); end
      rst = 1'b1;
      if0.redirect_i = 1'b1;
      if0.redirect_pc_i = 32'h0000_0080;
      if0.id_ready_i = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if0.redirect_i = 1'b0;
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b want 0", if0.id_valid_o); end
      n_checks++; if (if0.rom_ce_o !== 1'b0) begin n_errors++; $display("FAIL mid_ce: got %b want 0", if0.rom_ce_o); end
      n_checks++; if (if0.rom_addr_o !== 32'h0) begin n_errors++; $display("FAIL mid_addr: got %h want 0", if0.rom_addr_o); end
      n_checks++; if (if0.id_inst_o !== 32'h0) begin n_errors++; $display("FAIL mid_id_inst: got %h want 0", if0.id_inst_o); end
      @(negedge clk);
      n_checks++; if (if0.rom_ce_o !== 1'b1) begin n_errors++; $display("FAIL mid_restart_ce: got %b want 1", if0.rom_ce_o); end
      n_checks++; if (if0.id_valid_o !== 1'b0) begin n_errors++; $display("FAIL mid_restart_valid: got %b want 0", if0.id_valid_o); end
      exp_fill(32'h0, 4);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (if0.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL mid_valid[%0d]: got %b want 1", i, if0.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL mid_extra[%0d]: got %h want none", i, if0.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if0.id_pc_o, if0.id_inst_o} !== e) begin
               n_errors++; $display("FAIL mid_entry[%0d]: got %h want %h", i, {if0.id_pc_o, if0.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      logic [63:0] e;
      rst_w = 1'b0;
      @(negedge clk);
      n_checks++; if (if1.rom_addr_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_addr: got %h want fffffffc", if1.rom_addr_o); end
      exp_q.delete();
      exp_q.push_back({32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)});
      exp_q.push_back({32'h0000_0000, rom_word(32'h0000_0000)});
      exp_q.push_back({32'h0000_0004, rom_word(32'h0000_0004)});
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (if1.id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, if1.id_valid_o);
         end else if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL wrap_extra[%0d]: got %h want none", i, if1.id_pc_o);
         end else begin
            e = exp_q.pop_front();
            if ({if1.id_pc_o, if1.id_inst_o} !== e) begin
               n_errors++; $display("FAIL wrap_entry[%0d]: got %h want %h", i, {if1.id_pc_o, if1.id_inst_o}, e);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      rst_w = 1'b1;
      if0.id_ready_i = 1'b1;
      if0.redirect_i = 1'b0;
      if0.redirect_pc_i = 32'h0;
      if1.id_ready_i = 1'b1;
      if1.redirect_i = 1'b0;
      if1.redirect_pc_i = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_redirect_unaligned();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_inst_fetch
